// File: rtl/lab61soc_btn_pkg.sv
// Shared constants and types for the push-button Avalon-MM controller.
// Optional press counter is built when BTN_PRESS_COUNT_EN is defined.
package lab61soc_btn_pkg;

    // Word addresses inside the 4-word slave window
    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_MASK  = 2'd1;
    localparam logic [1:0] ADDR_EDGE  = 2'd2;
    localparam logic [1:0] ADDR_COUNT = 2'd3;

    // Width of the optional press counter
    localparam int PRESS_COUNT_W = 16;

    // Per-button debounce states
    typedef enum logic {
        STABLE = 1'b0,
        SETTLE = 1'b1
    } deb_state_e;

endpackage

// File: rtl/lab61soc_btn_debounce.sv
// One-button synchroniser plus debounce FSM. The debounced level only
// follows the synchronised input after it has disagreed for
// DEBOUNCE_CYCLES consecutive cycles; o_press pulses on the cycle a
// released->pressed (1->0) level change is accepted.
module lab61soc_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);
    import lab61soc_btn_pkg::*;

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] TERM_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic             w_syncBit;
    deb_state_e       r_state;
    deb_state_e       w_nextState;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_nextCount;
    logic             r_level;
    logic             w_nextLevel;

    assign w_syncBit = r_sync[1];

    // Two-flop synchroniser; idles at "released"
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_raw};
        end
    end

    // Debounce state, counter and accepted level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= STABLE;
            r_count <= '0;
            r_level <= 1'b1;
        end else begin
            r_state <= w_nextState;
            r_count <= w_nextCount;
            r_level <= w_nextLevel;
        end
    end

    // The first mismatching cycle already counts, so acceptance lands
    // exactly DEBOUNCE_CYCLES cycles after the synchronised step
    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        w_nextLevel = r_level;
        case (r_state)
            STABLE: begin
                if (w_syncBit != r_level) begin
                    w_nextState = SETTLE;
                    w_nextCount = CNT_W'(1);
                end else begin
                    w_nextCount = '0;
                end
            end
            SETTLE: begin
                if (w_syncBit == r_level) begin
                    w_nextState = STABLE;
                    w_nextCount = '0;
                end else if (r_count == TERM_COUNT) begin
                    w_nextState = STABLE;
                    w_nextCount = '0;
                    w_nextLevel = w_syncBit;
                end else begin
                    w_nextCount = r_count + CNT_W'(1);
                end
            end
            default: begin
                w_nextState = STABLE;
                w_nextCount = '0;
            end
        endcase
    end

    assign o_level = r_level;
    assign o_press = r_level & ~w_nextLevel;

endmodule

// File: rtl/lab61soc_btn_ctrl.sv
// Avalon-MM push-button controller: debounced levels, edge capture with
// maskable level IRQ, registered read mux (latency 1).
// Define BTN_PRESS_COUNT_EN to build the 16-bit saturating press counter
// at address 3; otherwise address 3 reads 0.
module lab61soc_btn_ctrl #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    import lab61soc_btn_pkg::*;

    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_press;
    logic [WIDTH-1:0] r_irqMask;
    logic [WIDTH-1:0] r_edgeCapture;
    logic             w_wrEn;
    logic [31:0]      w_readMux;
    logic             w_unusedWdata;

    assign w_wrEn        = chipselect & ~write_n;
    assign w_unusedWdata = ^{1'b0, writedata};

    for (genvar g = 0; g < WIDTH; g++) begin : g_btn
        lab61soc_btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset_n(reset_n),
            .i_raw  (in_port[g]),
            .o_level(w_level[g]),
            .o_press(w_press[g])
        );
    end

    // Interrupt mask register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irqMask <= '0;
        end else if (w_wrEn && address == ADDR_MASK) begin
            r_irqMask <= writedata[WIDTH-1:0];
        end
    end

    // Edge capture: write-1-to-clear, a simultaneous press wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edgeCapture <= '0;
        end else if (w_wrEn && address == ADDR_EDGE) begin
            r_edgeCapture <= (r_edgeCapture & ~writedata[WIDTH-1:0]) | w_press;
        end else begin
            r_edgeCapture <= r_edgeCapture | w_press;
        end
    end

`ifdef BTN_PRESS_COUNT_EN
    logic [PRESS_COUNT_W-1:0] r_pressCount;

    // Saturating count of cycles with any press; a write clears and wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pressCount <= '0;
        end else if (w_wrEn && address == ADDR_COUNT) begin
            r_pressCount <= '0;
        end else if ((|w_press) && (r_pressCount != '1)) begin
            r_pressCount <= r_pressCount + PRESS_COUNT_W'(1);
        end
    end
`endif

    // Read mux, zero-extended, independent of chipselect
    always_comb begin
        w_readMux = 32'd0;
        case (address)
            ADDR_DATA: w_readMux[WIDTH-1:0] = w_level;
            ADDR_MASK: w_readMux[WIDTH-1:0] = r_irqMask;
            ADDR_EDGE: w_readMux[WIDTH-1:0] = r_edgeCapture;
`ifdef BTN_PRESS_COUNT_EN
            ADDR_COUNT: w_readMux[PRESS_COUNT_W-1:0] = r_pressCount;
`endif
            default: w_readMux = 32'd0;
        endcase
    end

    // Registered read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= 32'd0;
        end else begin
            readdata <= w_readMux;
        end
    end

    assign irq = |(r_edgeCapture & r_irqMask);

endmodule

// File: tb/tb_lab61soc_btn_ctrl.sv
// Self-checking bench for lab61soc_btn_ctrl (WIDTH=2, DEBOUNCE_CYCLES=4).
// Directed scenario tasks plus a randomized phase checked against a
// cycle-level behavioural model. Press-counter checks follow
// BTN_PRESS_COUNT_EN.
module tb_lab61soc_btn_ctrl;

    localparam int W = 2;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    address = 2'd0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = 32'd0;
    logic [31:0]   readdata;
    logic [W-1:0]  in_port = '1;
    logic          irq;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    lab61soc_btn_ctrl #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    // Behavioural model: a level is accepted once the synchronised input
    // has disagreed with it for D consecutive clock edges
    logic [W-1:0] mS1, mS2, mLevel, mEdge, mMask, mNextLevel, mPress;
    logic [31:0]  mRead, mNextRead;
    logic         mWr;
    int           mRun [W];
`ifdef BTN_PRESS_COUNT_EN
    logic [15:0]  mCount;
    logic         forceSat = 1'b0;
`endif

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mS1 = '1; mS2 = '1; mLevel = '1; mEdge = '0; mMask = '0; mRead = '0;
            for (int i = 0; i < W; i++) mRun[i] = 0;
`ifdef BTN_PRESS_COUNT_EN
            mCount = '0;
`endif
        end else begin
            mWr = chipselect && !write_n;
            mNextRead = 32'd0;
            case (address)
                2'd0: mNextRead[W-1:0] = mLevel;
                2'd1: mNextRead[W-1:0] = mMask;
                2'd2: mNextRead[W-1:0] = mEdge;
                default: begin
`ifdef BTN_PRESS_COUNT_EN
                    mNextRead = {16'd0, mCount};
`endif
                end
            endcase
            mNextLevel = mLevel;
            mPress = '0;
            for (int i = 0; i < W; i++) begin
                if (mS2[i] !== mLevel[i]) begin
                    mRun[i]++;
                    if (mRun[i] == D) begin
                        mNextLevel[i] = mS2[i];
                        mPress[i] = ~mS2[i];
                        mRun[i] = 0;
                    end
                end else begin
                    mRun[i] = 0;
                end
            end
            if (mWr && address == 2'd2) mEdge = mEdge & ~writedata[W-1:0];
            mEdge = mEdge | mPress;
            if (mWr && address == 2'd1) mMask = writedata[W-1:0];
`ifdef BTN_PRESS_COUNT_EN
            if (forceSat) mCount = 16'hFFFF;
            else if (mWr && address == 2'd3) mCount = 16'd0;
            else if ((|mPress) && mCount != 16'hFFFF) mCount = mCount + 16'd1;
`endif
            mS2 = mS1;
            mS1 = in_port;
            mLevel = mNextLevel;
            mRead = mNextRead;
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_port = '1;
        waitCycles(3);
        nChecks++;
        if (readdata !== 32'd0 || irq !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL reset_hold: readdata=%h irq=%b, want 0/0", readdata, irq);
        end
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            @(negedge clk);
            nChecks++;
            if (readdata !== ((a == 0) ? 32'h3 : 32'h0)) begin
                nFails++;
                $display("[TB] FAIL reset_addr%0d: readdata=%h, want %h", a, readdata, (a == 0) ? 32'h3 : 32'h0);
            end
        end
        nChecks++;
        if (irq !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL reset_irq: irq=%b, want 0", irq);
        end
    endtask

    task automatic test_clean_press();
        address = 2'd0;
        in_port[0] = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 6) begin
                nChecks++;
                if (readdata[0] !== 1'b1) begin
                    nFails++;
                    $display("[TB] FAIL press_early: data bit0=%b, want 1", readdata[0]);
                end
            end
            if (c == 7) begin
                nChecks++;
                if (readdata[0] !== 1'b0) begin
                    nFails++;
                    $display("[TB] FAIL press_latency: data bit0=%b, want 0", readdata[0]);
                end
            end
        end
        address = 2'd2;
        @(negedge clk);
        nChecks++;
        if (readdata !== 32'h1 || irq !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL press_edge: edge=%h irq=%b, want 1/0", readdata, irq);
        end
    endtask

    task automatic test_bounce();
        in_port[0] = 1'b1;
        waitCycles(8);
        address = 2'd0;
        for (int k = 0; k < 4; k++) begin
            in_port[1] = k[0];
            waitCycles(2);
            nChecks++;
            if (readdata !== 32'h3) begin
                nFails++;
                $display("[TB] FAIL bounce_data%0d: data=%h, want 3", k, readdata);
            end
        end
        waitCycles(8);
        nChecks++;
        if (readdata !== 32'h3) begin
            nFails++;
            $display("[TB] FAIL bounce_settled: data=%h, want 3", readdata);
        end
        address = 2'd2;
        waitCycles(1);
        nChecks++;
        if (readdata !== 32'h1) begin
            nFails++;
            $display("[TB] FAIL bounce_edge: edge=%h, want 1", readdata);
        end
    endtask

    task automatic test_irq_flow();
        busWrite(2'd2, 32'h3);
        busWrite(2'd1, 32'h1);
        nChecks++;
        if (irq !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL irq_idle: irq=%b, want 0", irq);
        end
        in_port[0] = 1'b0;
        waitCycles(8);
        nChecks++;
        if (irq !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL irq_assert: irq=%b, want 1", irq);
        end
        busWrite(2'd2, 32'h1);
        nChecks++;
        if (irq !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL irq_clear: irq=%b, want 0", irq);
        end
        in_port[0] = 1'b1;
        waitCycles(8);
        in_port[0] = 1'b0;
        waitCycles(5);
        busWrite(2'd2, 32'h1);
        nChecks++;
        if (irq !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL irq_set_wins: irq=%b, want 1", irq);
        end
        address = 2'd2;
        waitCycles(2);
        nChecks++;
        if (readdata !== 32'h1) begin
            nFails++;
            $display("[TB] FAIL edge_set_wins: edge=%h, want 1", readdata);
        end
    endtask

    task automatic test_reset_mid();
        in_port[1] = 1'b0;
        waitCycles(4);
        reset_n = 1'b0;
        #1;
        nChecks++;
        if (readdata !== 32'd0 || irq !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL midreset_regs: readdata=%h irq=%b, want 0/0", readdata, irq);
        end
        waitCycles(2);
        address = 2'd2;
        reset_n = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 6) begin
                nChecks++;
                if (readdata !== 32'h0) begin
                    nFails++;
                    $display("[TB] FAIL midreset_early: edge=%h, want 0", readdata);
                end
            end
            if (c == 7) begin
                nChecks++;
                if (readdata !== 32'h3) begin
                    nFails++;
                    $display("[TB] FAIL midreset_press: edge=%h, want 3", readdata);
                end
            end
        end
        address = 2'd1;
        waitCycles(1);
        nChecks++;
        if (readdata !== 32'h0 || irq !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL midreset_mask: mask=%h irq=%b, want 0/0", readdata, irq);
        end
    endtask

    task automatic test_press_count();
`ifdef BTN_PRESS_COUNT_EN
        in_port = '1;
        waitCycles(8);
        busWrite(2'd3, 32'h0);
        in_port = 2'b00; waitCycles(8);
        in_port = 2'b10; waitCycles(8);
        in_port = 2'b00; waitCycles(8);
        address = 2'd3;
        waitCycles(2);
        nChecks++;
        if (readdata !== 32'd2) begin
            nFails++;
            $display("[TB] FAIL count_two: count=%h, want 2", readdata);
        end
        in_port = 2'b10; waitCycles(8);
        force dut.r_pressCount = 16'hFFFF;
        forceSat = 1'b1;
        @(negedge clk);
        release dut.r_pressCount;
        forceSat = 1'b0;
        in_port = 2'b00; waitCycles(8);
        nChecks++;
        if (readdata !== 32'hFFFF) begin
            nFails++;
            $display("[TB] FAIL count_saturate: count=%h, want ffff", readdata);
        end
        busWrite(2'd3, 32'h0);
        address = 2'd3;
        waitCycles(2);
        nChecks++;
        if (readdata !== 32'd0) begin
            nFails++;
            $display("[TB] FAIL count_clear: count=%h, want 0", readdata);
        end
`else
        busWrite(2'd3, $urandom);
        in_port = 2'b10; waitCycles(8);
        in_port = 2'b00; waitCycles(8);
        address = 2'd3;
        waitCycles(2);
        nChecks++;
        if (readdata !== 32'd0) begin
            nFails++;
            $display("[TB] FAIL count_absent: addr3=%h, want 0", readdata);
        end
`endif
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            nChecks++;
            if (readdata !== mRead) begin
                nFails++;
                $display("[TB] FAIL rand_readdata cyc %0d: got %h, want %h", c, readdata, mRead);
            end
            nChecks++;
            if (irq !== |(mEdge & mMask)) begin
                nFails++;
                $display("[TB] FAIL rand_irq cyc %0d: got %b, want %b", c, irq, |(mEdge & mMask));
            end
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(0, 5) == 0) in_port[i] = ~in_port[i];
            end
            address = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                chipselect = 1'b1; write_n = 1'b0; writedata = $urandom;
            end else begin
                chipselect = $urandom_range(0, 1) == 1; write_n = 1'b1;
            end
            @(negedge clk);
        end
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_irq_flow();
        test_reset_mid();
        test_press_count();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
